// File: rtl/sha_pipelined_post_stage.sv
// SHA post stage: feed-forward add, digest FIFO, overflow flag and counters.
// Optional SHA_POST_TARGET_EN: only digests <= target_i are queued.
package sha_post_pkg;

  typedef logic [255:0] hash_state_t;

  typedef struct packed {
    hash_state_t digest;
    logic        newblock;
  } post_entry_t;

endpackage

module sha_pipelined_post_stage
  import sha_post_pkg::*;
#(
  parameter int FIFO_DEPTH         = 4,
  parameter int ADD_PIPELINE_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  hash_state_t state_i,
  input  hash_state_t hin_i,
  input  logic        valid_i,
  input  logic        newblock_i,
  input  logic        clear_i,
`ifdef SHA_POST_TARGET_EN
  input  hash_state_t target_i,
  output logic [31:0] hit_count_o,
`endif
  output hash_state_t digest_o,
  output logic        digest_valid_o,
  input  logic        digest_ready_i,
  output logic        newblock_o,
  output logic        overflow_o,
  output logic [31:0] count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  hash_state_t sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i*32 +: 32] = state_i[i*32 +: 32]
                      + hin_i[i*32 +: 32];
    end
  end

  logic        pres_v;
  hash_state_t pres_sum;
  logic        pres_nb;

  generate
    if (ADD_PIPELINE_DEPTH == 1) begin : g_add_reg
      logic        v_q;
      hash_state_t sum_q;
      logic        nb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else begin
          v_q <= valid_i;
        end
      end

      // data flops carry no reset; only the valid bit matters
      always_ff @(posedge clk) begin
        if (valid_i) begin
          sum_q <= sum;
          nb_q  <= newblock_i;
        end
      end

      assign pres_v   = v_q;
      assign pres_sum = sum_q;
      assign pres_nb  = nb_q;
    end else begin : g_add_comb
      assign pres_v   = valid_i;
      assign pres_sum = sum;
      assign pres_nb  = newblock_i;
    end
  endgenerate

  logic push_req;

`ifdef SHA_POST_TARGET_EN
  logic hit;
  assign hit      = (pres_sum <= target_i);
  assign push_req = pres_v & hit;
`else
  assign push_req = pres_v;
`endif

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  post_entry_t mem_q [FIFO_DEPTH];
  post_entry_t last_q, last_d;
  post_entry_t head;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW])
               && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // a pop frees the slot on the same edge a full FIFO is pushed
  assign pop  = ~empty & digest_ready_i;
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  assign head = empty ? last_q : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    last_d = last_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      last_d = mem_q[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= '{digest: pres_sum, newblock: pres_nb};
    end
  end

  assign digest_o       = head.digest;
  assign newblock_o     = head.newblock;
  assign digest_valid_o = ~empty;

  logic [31:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        cnt_inc;

`ifdef SHA_POST_TARGET_EN
  assign cnt_inc = pres_v;
`else
  assign cnt_inc = push;
`endif

  // an increment on the clearing edge leaves the counter at one
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (cnt_inc) begin
      count_d = count_d + 32'd1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

`ifdef SHA_POST_TARGET_EN
  logic [31:0] hits_q, hits_d;

  always_comb begin
    hits_d = hits_q;
    if (clear_i) begin
      hits_d = '0;
    end
    if (push) begin
      hits_d = hits_d + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end

  assign hit_count_o = hits_q;
`endif

endmodule

// File: tb/tb_sha_pipelined_post_stage.sv
// Bench for sha_pipelined_post_stage: queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_sha_pipelined_post_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] state_i = '0;
  logic [255:0] hin_i = '0;
  logic         valid_i = 1'b0;
  logic         newblock_i = 1'b0;
  logic         clear_i = 1'b0;
  logic         digest_ready_i = 1'b0;
  logic [255:0] digest_o;
  logic         digest_valid_o;
  logic         newblock_o;
  logic         overflow_o;
  logic [31:0]  count_o;
`ifdef SHA_POST_TARGET_EN
  logic [255:0] target_i = '1;
  logic [31:0]  hit_count_o;
`endif

  sha_pipelined_post_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .state_i        (state_i),
    .hin_i          (hin_i),
    .valid_i        (valid_i),
    .newblock_i     (newblock_i),
    .clear_i        (clear_i),
`ifdef SHA_POST_TARGET_EN
    .target_i       (target_i),
    .hit_count_o    (hit_count_o),
`endif
    .digest_o       (digest_o),
    .digest_valid_o (digest_valid_o),
    .digest_ready_i (digest_ready_i),
    .newblock_o     (newblock_o),
    .overflow_o     (overflow_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] add8(input logic [255:0] s,
                                        input logic [255:0] h);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = s[i*32 +: 32] + h[i*32 +: 32];
    return r;
  endfunction

  typedef struct {
    logic [255:0] d;
    logic         nb;
  } ent_t;

  ent_t         q[$];
  logic [255:0] m_last = '0;
  logic         m_last_nb = 1'b0;
  logic [31:0]  m_count = '0;
  logic [31:0]  m_hits = '0;
  logic         m_ovf = 1'b0;
  logic         p_v = 1'b0;
  logic [255:0] p_s = '0;
  logic         p_nb = 1'b0;

  // model: one cycle of adder latency, then a 4-deep queue
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last = '0; m_last_nb = 1'b0;
      m_count = '0; m_hits = '0; m_ovf = 1'b0;
      p_v = 1'b0;
    end else begin
      bit take, wr, drop;
      take = p_v;
`ifdef SHA_POST_TARGET_EN
      take = p_v && (p_s <= target_i);
`endif
      if (q.size() > 0 && digest_ready_i) begin
        m_last = q[0].d; m_last_nb = q[0].nb;
        void'(q.pop_front());
      end
      wr = 0; drop = 0;
      if (take) begin
        if (q.size() < 4) begin
          q.push_back('{p_s, p_nb});
          wr = 1;
        end else drop = 1;
      end
      if (clear_i) begin
        m_count = '0; m_ovf = 1'b0; m_hits = '0;
      end
`ifdef SHA_POST_TARGET_EN
      if (p_v) m_count++;
      if (wr) m_hits++;
`else
      if (wr) m_count++;
`endif
      if (drop) m_ovf = 1'b1;
      p_v = valid_i;
      p_s = add8(state_i, hin_i);
      p_nb = newblock_i;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", digest_valid_o, q.size() > 0);
      if (q.size() > 0) begin
        chk("m_digest", digest_o, q[0].d);
        chk("m_newblock", newblock_o, q[0].nb);
      end else begin
        chk("m_digest_hold", digest_o, m_last);
      end
      chk("m_count", count_o, m_count);
      chk("m_overflow", overflow_o, m_ovf);
`ifdef SHA_POST_TARGET_EN
      chk("m_hits", hit_count_o, m_hits);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] s, input logic [255:0] h,
                      input logic nb);
    state_i = s; hin_i = h; newblock_i = nb; valid_i = 1'b1;
    step();
    valid_i = 1'b0; newblock_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_valid", digest_valid_o, 0);
    chk("reset_digest", digest_o, 0);
    chk("reset_newblock", newblock_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_overflow", overflow_o, 0);

    // word wrap
    digest_ready_i = 1'b1;
    send({8{32'h2}}, {8{32'hFFFFFFFF}}, 1'b1);
    step();
    chk("wrap_valid", digest_valid_o, 1);
    chk("wrap_digest", digest_o, {8{32'h1}});
    chk("wrap_count", count_o, 1);
    step();
    chk("wrap_valid_gone", digest_valid_o, 0);

    // backpressure and overflow
    digest_ready_i = 1'b0;
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("clr_count", count_o, 0);
    for (int i = 0; i < 5; i++) begin
      state_i = {8{32'(i)}}; hin_i = {8{32'h100}};
      newblock_i = (i == 0); valid_i = 1'b1;
      step();
    end
    valid_i = 1'b0; newblock_i = 1'b0;
    step(); step();
    chk("bp_overflow", overflow_o, 1);
    chk("bp_count", count_o, 4);
    digest_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_pop_valid", digest_valid_o, 1);
      chk("bp_pop_nb", newblock_o, i == 0);
      chk("bp_pop_digest", digest_o, {8{32'(i) + 32'h100}});
      step();
    end
    chk("bp_empty", digest_valid_o, 0);
    digest_ready_i = 1'b0;

    // full with simultaneous pop and push
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("fp_clr_ovf", overflow_o, 0);
    for (int i = 0; i < 4; i++) begin
      state_i = {8{32'(i + 10)}}; hin_i = '0; valid_i = 1'b1;
      step();
    end
    valid_i = 1'b0;
    step(); step();
    chk("fp_count4", count_o, 4);
    send({8{32'h55}}, {8{32'h1}}, 1'b0);
    digest_ready_i = 1'b1;
    step();
    digest_ready_i = 1'b0;
    chk("fp_no_ovf", overflow_o, 0);
    chk("fp_count5", count_o, 5);
    send({8{32'h66}}, '0, 1'b0);
    step();
    chk("fp_still_full", overflow_o, 1);
    chk("fp_count_hold", count_o, 5);

    // clear with simultaneous write
    digest_ready_i = 1'b1;
    repeat (5) step();
    digest_ready_i = 1'b0;
    chk("cw_drained", digest_valid_o, 0);
    send({8{32'h7}}, {8{32'h7}}, 1'b1);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("cw_ovf", overflow_o, 0);
    chk("cw_count", count_o, 1);

    // async reset with entries buffered
    send({8{32'h8}}, '0, 1'b0);
    send({8{32'h9}}, '0, 1'b0);
    step(); step();
    chk("ar_pre_valid", digest_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", digest_valid_o, 0);
    chk("ar_count", count_o, 0);
    chk("ar_ovf", overflow_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("ar_post_valid", digest_valid_o, 0);
    chk("ar_post_digest", digest_o, 0);

`ifdef SHA_POST_TARGET_EN
    target_i = {32'h0000FFFF, {7{32'hFFFFFFFF}}};
    send({32'h00001234, 224'h0}, '0, 1'b1);
    send({32'h00010000, 224'h0}, '0, 1'b0);
    step(); step();
    chk("tg_count", count_o, 2);
    chk("tg_hits", hit_count_o, 1);
    chk("tg_digest", digest_o, {32'h00001234, 224'h0});
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_pipelined_post_stage.md
Name: sha_pipelined_post_stage

Overview:
- Tail end of the super-pipelined SHA core; consumes the per-cycle output of the last pipelined round stage (state, valid, newblock).
- Performs the final feed-forward addition (digest = block input hash + round output, per 32-bit word, mod 2^32).
- Buffers digests in a small FIFO and hands them to a downstream consumer over a valid/ready handshake.
- The round pipeline cannot stall, so the block detects and flags overflow instead of back-pressuring.

Parameters:
FIFO_DEPTH, 4, digest FIFO entries; power of two, >= 2
ADD_PIPELINE_DEPTH, 1, register stages on the feed-forward adder; legal values 0 or 1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
state_i  input  HashState(256)  round output words a..h from the last round stage
hin_i  input  HashState(256)  hash state the block entered the pipeline with, carried alongside
valid_i  input  1  state_i/hin_i/newblock_i valid this cycle
newblock_i  input  1  tag: first block of a new message
clear_i  input  1  synchronous clear of overflow_o and count_o
digest_o  output  HashState(256)  FIFO head digest
digest_valid_o  output  1  FIFO non-empty
digest_ready_i  input  1  consumer accepts head this cycle
newblock_o  output  1  newblock tag of FIFO head
overflow_o  output  1  sticky: a digest was dropped because FIFO was full
count_o  output  32  digests accepted into the FIFO since reset/clear; wraps

Behaviour:
- Reset (rst_n low, async): FIFO empty, digest_valid_o=0, newblock_o=0, digest_o=0, overflow_o=0, count_o=0, adder valid pipe=0. Data flops in the adder stage need no reset, but their valid bit must be reset.
- Adder: each word i of sum = state_i.word[i] + hin_i.word[i], truncated to 32 bits; carries never cross words.
- ADD_PIPELINE_DEPTH=1: sum, valid and newblock are registered, so the entry is presented to the FIFO write port 1 cycle after valid_i. With 0, the write happens in the same cycle.
- FIFO write: on a presented valid entry, if not full, write {sum, newblock} and increment count_o.
- If the FIFO is full at that edge: drop the entry, set overflow_o, leave count_o unchanged.
- Simultaneous pop and push when full: the pop frees the slot in the same edge, so the push succeeds and no overflow occurs.
- FIFO read: pop on digest_valid_o && digest_ready_i. Latency from write to digest_valid_o is 1 cycle (registered output, first-word-fall-through). digest_o/newblock_o are stable while digest_valid_o=1 and ready=0.
- Empty FIFO: digest_ready_i is ignored; digest_o holds its last value.
- Pointers: log2(FIFO_DEPTH)+1 bits; full/empty derived from MSB compare. Pointers wrap naturally.
- clear_i: at the next edge, overflow_o=0 and count_o=0. If a write happens on the same edge, count_o=1 (a successful write overrides the clear of the counter). Overflow on the same edge as clear: overflow_o=1 (set wins). FIFO contents are unaffected.
- count_o wraps 0xFFFFFFFF -> 0.
- Reset mid-operation discards all in-flight and buffered digests; nothing is emitted afterwards until new valid_i.

Optional Feature:
- Macro: SHA_POST_TARGET_EN.
- Defined:
  - Adds input target_i (256) and output hit_count_o (32, reset 0, cleared by clear_i, wraps).
  - Digest compared as a 256-bit unsigned value {a,b,c,d,e,f,g,h}, with a most significant; compare happens in the adder output stage.
  - Only digests <= target_i are written to the FIFO; each such write increments hit_count_o.
  - count_o counts every valid digest presented, whether or not it is a hit.
  - overflow_o applies only to dropped hits.
- Undefined: target_i and hit_count_o are absent; every valid digest is written.

Test Plan:
- Word wrap: hin_i all words 0xFFFFFFFF, state_i all words 0x00000002, one valid_i pulse, ready=1 -> 2 cycles later (DEPTH=1) digest_valid_o=1 for 1 cycle, all digest words 0x00000001, count_o=1.
- Backpressure/overflow: ready=0, 5 consecutive valid_i with newblock_i=1,0,0,0,0 -> 4 entries stored, overflow_o=1, count_o=4. Then ready=1 -> 4 pops in order, first newblock_o=1, others 0.
- Full with simultaneous pop: FIFO full, valid entry arrives on the same edge as a pop -> no overflow, occupancy stays 4, count_o increments.
- clear_i with simultaneous write -> overflow_o=0, count_o=1.
- Async reset mid-stream: assert rst_n=0 between edges with 3 entries buffered -> digest_valid_o=0 immediately, count_o=0. Releasing reset yields no spurious output.
- SHA_POST_TARGET_EN: target_i=0x0000FFFF..FF. Digests with word a=0x00001234 and a=0x00010000 -> only the first is enqueued, hit_count_o=1, count_o=2.
